reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 100 ++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on / soft-reset sequencer releasing reset domains in index order
module reset_sequencer #(
    parameter int CNT_WIDTH  = 14,
    parameter int CHANNELS   = 4,
    parameter int STAGE_GAP  = 64,
    parameter int PROG_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  resetn_in,
    input  logic                  hold,
    input  logic                  soft_rst,
    output logic [CHANNELS-1:0]   resetn_out,
    output logic                  busy,
    output logic [PROG_WIDTH-1:0] progress,
    output logic [7:0]            restarts
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_COUNT,
        S_STAGE,
        S_RUN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [15:0]          GAP_LAST = 16'(STAGE_GAP - 1);
    localparam logic [2:0]           IDX_LAST = 3'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0]  ONE      = CHANNELS'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [15:0]          gap;
    logic [2:0]           idx;

    // cnt is a register and saturates at max, so progress reads all ones in RUN
    assign progress = cnt[CNT_WIDTH-1 -: PROG_WIDTH];

    always_ff @(posedge CLK or negedge resetn_in) begin
        if (!resetn_in) begin
            state      <= S_WAIT;
            cnt        <= '0;
            gap        <= '0;
            idx        <= '0;
            resetn_out <= '0;
            busy       <= 1'b1;
            restarts   <= '0;
        end else if (hold || soft_rst) begin
            // restart wins over every transition, including a release edge
            if (state == S_RUN && restarts != 8'hFF)
                restarts <= restarts + 8'd1;
            state      <= S_WAIT;
            cnt        <= '0;
            gap        <= '0;
            idx        <= '0;
            resetn_out <= '0;
            busy       <= 1'b1;
        end else begin
            case (state)
                S_WAIT: begin
                    state <= S_COUNT;
                end
                S_COUNT: begin
                    if (cnt == CNT_MAX) begin
                        resetn_out[0] <= 1'b1;
                        gap           <= '0;
                        idx           <= 3'd1;
                        if (CHANNELS == 1) begin
                            state <= S_RUN;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_STAGE;
                        end
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_STAGE: begin
                    if (gap == GAP_LAST) begin
                        resetn_out <= resetn_out | (ONE << idx);
                        gap        <= '0;
                        idx        <= idx + 3'd1;
                        if (idx == IDX_LAST) begin
                            state <= S_RUN;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       CLK = 1'b0;
    logic       resetn_in;
    logic       hold;
    logic       soft_rst;

    logic [2:0] a_rst;
    logic       a_busy;
    logic [3:0] a_prog;
    logic [7:0] a_restarts;

    logic [0:0] b_rst;
    logic       b_busy;
    logic [3:0] b_prog;
    logic [7:0] b_restarts;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    reset_sequencer #(
        .CNT_WIDTH (4),
        .CHANNELS  (3),
        .STAGE_GAP (2),
        .PROG_WIDTH(4)
    ) dut_a (
        .CLK       (CLK),
        .resetn_in (resetn_in),
        .hold      (hold),
        .soft_rst  (soft_rst),
        .resetn_out(a_rst),
        .busy      (a_busy),
        .progress  (a_prog),
        .restarts  (a_restarts)
    );

    reset_sequencer #(
        .CNT_WIDTH (4),
        .CHANNELS  (1),
        .STAGE_GAP (1),
        .PROG_WIDTH(4)
    ) dut_b (
        .CLK       (CLK),
        .resetn_in (resetn_in),
        .hold      (hold),
        .soft_rst  (soft_rst),
        .resetn_out(b_rst),
        .busy      (b_busy),
        .progress  (b_prog),
        .restarts  (b_restarts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    // edges counted from the reference edge (reset release or last restart edge)
    task automatic run_schedule(input string tag);
        logic [2:0] exp_rst;
        int         exp_prog;
        for (int e = 1; e <= 21; e++) begin
            edge1();
            exp_rst  = {e >= 21, e >= 19, e >= 17};
            exp_prog = (e <= 1) ? 0 : ((e - 1 > 15) ? 15 : e - 1);
            check($sformatf("%s_a_rst_e%0d", tag, e), a_rst, exp_rst);
            check($sformatf("%s_a_busy_e%0d", tag, e), a_busy, (e >= 21) ? 0 : 1);
            check($sformatf("%s_a_prog_e%0d", tag, e), a_prog, exp_prog);
            check($sformatf("%s_b_rst_e%0d", tag, e), b_rst, (e >= 17) ? 1 : 0);
            check($sformatf("%s_b_busy_e%0d", tag, e), b_busy, (e >= 17) ? 0 : 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        resetn_in = 1'b0;
        hold      = 1'b0;
        soft_rst  = 1'b0;

        // reset values
        #23;
        check("rst_a_rst", a_rst, 0);
        check("rst_a_busy", a_busy, 1);
        check("rst_a_prog", a_prog, 0);
        check("rst_a_restarts", a_restarts, 0);
        check("rst_b_rst", b_rst, 0);
        check("rst_b_busy", b_busy, 1);

        // power-on schedule
        @(negedge CLK);
        resetn_in = 1'b1;
        run_schedule("pon");
        edge1();
        check("pon_run_rst", a_rst, 3'b111);
        check("pon_run_busy", a_busy, 0);
        check("pon_run_prog", a_prog, 4'hF);
        check("pon_run_restarts", a_restarts, 0);
        check("pon_b_prog", b_prog, 4'hF);
        check("pon_b_restarts", b_restarts, 0);

        // hold for 30 edges after a fresh reset
        resetn_in = 1'b0;
        #2;
        hold      = 1'b1;
        resetn_in = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            edge1();
            check($sformatf("hold_rst_e%0d", e), a_rst, 0);
            check($sformatf("hold_prog_e%0d", e), a_prog, 0);
            check($sformatf("hold_busy_e%0d", e), a_busy, 1);
        end
        hold = 1'b0;
        run_schedule("hold");
        check("hold_restarts", a_restarts, 0);

        // soft restart from RUN
        soft_rst = 1'b1;
        edge1();
        soft_rst = 1'b0;
        check("soft_rst_out", a_rst, 0);
        check("soft_busy", a_busy, 1);
        check("soft_prog", a_prog, 0);
        check("soft_restarts", a_restarts, 1);
        run_schedule("soft");

        // soft restart on the edge that would release ch1
        resetn_in = 1'b0;
        #2;
        resetn_in = 1'b1;
        for (int e = 1; e <= 18; e++) edge1();
        check("mid_pre_rst", a_rst, 3'b001);
        soft_rst = 1'b1;
        edge1();
        soft_rst = 1'b0;
        check("mid_rst", a_rst, 0);
        check("mid_busy", a_busy, 1);
        check("mid_restarts", a_restarts, 0);

        // saturation of the restart counter
        for (int i = 0; i < 300; i++) begin
            k = 0;
            while (a_busy && k < 40) begin
                edge1();
                k++;
            end
            if (a_busy)
                check($sformatf("sat_wait_run_%0d", i), a_busy, 0);
            soft_rst = 1'b1;
            edge1();
            soft_rst = 1'b0;
            if (i == 0 || i == 254 || i == 299)
                check($sformatf("sat_restarts_%0d", i), a_restarts, (i + 1 > 255) ? 255 : i + 1);
        end

        // asynchronous reset away from the clock edge
        #3;
        resetn_in = 1'b0;
        #1;
        check("async_restarts", a_restarts, 0);
        check("async_rst", a_rst, 0);
        check("async_busy", a_busy, 1);
        check("async_prog", a_prog, 0);
        check("async_b_restarts", b_restarts, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
